mdu_sched: RTL and testbench

- Sequencing controller for the multiply/divide unit in the E stage of the pipelined MIPS core.
- Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo commands from E-stage decode.
- Latches operands, runs a cycle-accurate latency countdown, commits HI/LO on completion, and drives the Busy signal that the stall unit consumes.
- Honours the exception/interrupt Req flush: a start presented in the same cycle as Req is cancelled.

---
 rtl/mdu_sched.sv | 216 +++++++++++++++++++++
 tb/tb_mdu_sched.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sched.sv
// mdu_sched
// Sequencing controller for the multiply/divide unit in the E stage of the
// pipelined MIPS core. It latches operands for mult/multu/div/divu, counts
// down the fixed latency, commits HI/LO when the countdown ends, and reports
// busy to the stall unit. mthi/mtlo write HI/LO directly at the accept edge;
// mfhi/mflo are served combinationally on o_rdata.
//
// Optional feature macro: MDU_SCHED_EARLY_EXIT_EN
//   When defined, a mult/multu with a zero operand, or a div/divu by zero,
//   skips the countdown and goes straight to COMMIT (busy never rises).
//
// Parameters:
//   MUL_CYCLES  busy cycles for mult/multu (1..31)
//   DIV_CYCLES  busy cycles for div/divu   (1..31)
//
// Ports:
//   i_clk    system clock, rising edge
//   i_reset  asynchronous reset, active-low (0 = reset)
//   i_req    exception/interrupt flush; blocks acceptance of a new start
//   i_start  E-stage instruction is an MDU command this cycle
//   i_op     0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//            7 mfhi, 8 mflo, 9-15 none
//   i_rs     forwarded rs operand
//   i_rt     forwarded rt operand
//   o_busy   long operation in progress
//   o_done   one-cycle pulse, new HI/LO visible this cycle
//   o_hi     architectural HI
//   o_lo     architectural LO
//   o_rdata  HI for mfhi, LO for mflo, otherwise 0 (combinational)

module mdu_sched #(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req,
   input  logic        i_start,
   input  logic [3:0]  i_op,
   input  logic [31:0] i_rs,
   input  logic [31:0] i_rt,
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_hi,
   output logic [31:0] o_lo,
   output logic [31:0] o_rdata
);

   typedef enum logic [1:0] {IDLE, RUN, COMMIT} state_t;

   localparam logic [4:0] MUL_LOAD = 5'(MUL_CYCLES - 1);
   localparam logic [4:0] DIV_LOAD = 5'(DIV_CYCLES - 1);

   state_t      r_state;
   state_t      w_nextState;
   logic [4:0]  r_count;
   logic [4:0]  w_nextCount;
   logic [3:0]  r_op;
   logic [31:0] r_rs;
   logic [31:0] r_rt;
   logic [31:0] r_hi;
   logic [31:0] r_lo;

   logic        w_accept;
   logic        w_isMul;
   logic        w_isLong;
   logic        w_shortcut;
   logic        w_latchOps;
   logic        w_commit;

   // COMMIT accepts a new command exactly like IDLE so back-to-back ops lose no cycle
   assign w_accept = i_start & ~i_req & (r_state != RUN);
   assign w_isMul  = (i_op == 4'd1) | (i_op == 4'd2);
   assign w_isLong = (i_op >= 4'd1) & (i_op <= 4'd4);

`ifdef MDU_SCHED_EARLY_EXIT_EN
   // Trivial operations whose result is known without running the countdown
   assign w_shortcut = w_isMul ? ((i_rs == 32'd0) | (i_rt == 32'd0))
                               : (i_rt == 32'd0);
`else
   assign w_shortcut = 1'b0;
`endif

   // Next-state logic: RUN counts down to zero then commits; IDLE and COMMIT
   // both return to IDLE unless a long op is accepted
   always_comb begin
      w_nextState = r_state;
      w_nextCount = r_count;
      w_latchOps  = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         RUN: begin
            if (r_count == 5'd0) begin
               w_nextState = COMMIT;
               w_commit    = 1'b1;
            end else begin
               w_nextCount = r_count - 5'd1;
            end
         end
         default: begin
            w_nextState = IDLE;
            if (w_accept && w_isLong) begin
               w_latchOps = 1'b1;
               if (w_shortcut) begin
                  w_nextState = COMMIT;
               end else begin
                  w_nextState = RUN;
                  w_nextCount = w_isMul ? MUL_LOAD : DIV_LOAD;
               end
            end
         end
      endcase
   end

   // State and countdown registers
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= IDLE;
         r_count <= 5'd0;
      end else begin
         r_state <= w_nextState;
         r_count <= w_nextCount;
      end
   end

   // Result datapath from latched operands. Signed division works on
   // magnitudes so 0x80000000 / -1 wraps to 0x80000000 with remainder 0,
   // and a zero divisor is replaced by 1 only to keep the divider defined.
   logic signed [63:0] w_prodS;
   logic [63:0] w_prodU;
   logic [31:0] w_divisor;
   logic [31:0] w_absRs;
   logic [31:0] w_absRt;
   logic [31:0] w_qMag;
   logic [31:0] w_rMag;
   logic [31:0] w_resHi;
   logic [31:0] w_resLo;
   logic        w_resWrite;

   assign w_prodS   = $signed({{32{r_rs[31]}}, r_rs}) * $signed({{32{r_rt[31]}}, r_rt});
   assign w_prodU   = {32'd0, r_rs} * {32'd0, r_rt};
   assign w_divisor = (r_rt == 32'd0) ? 32'd1 : r_rt;
   assign w_absRs   = r_rs[31] ? (32'd0 - r_rs) : r_rs;
   assign w_absRt   = w_divisor[31] ? (32'd0 - w_divisor) : w_divisor;
   assign w_qMag    = w_absRs / w_absRt;
   assign w_rMag    = w_absRs % w_absRt;

   // Select the HI/LO values the latched op produces; a divide by zero
   // leaves HI/LO untouched
   always_comb begin
      w_resHi    = r_hi;
      w_resLo    = r_lo;
      w_resWrite = 1'b1;
      case (r_op)
         4'd1: begin
            w_resHi = w_prodS[63:32];
            w_resLo = w_prodS[31:0];
         end
         4'd2: begin
            w_resHi = w_prodU[63:32];
            w_resLo = w_prodU[31:0];
         end
         4'd3: begin
            w_resWrite = (r_rt != 32'd0);
            w_resLo    = (r_rs[31] ^ r_rt[31]) ? (32'd0 - w_qMag) : w_qMag;
            w_resHi    = r_rs[31] ? (32'd0 - w_rMag) : w_rMag;
         end
         4'd4: begin
            w_resWrite = (r_rt != 32'd0);
            w_resLo    = r_rs / w_divisor;
            w_resHi    = r_rs % w_divisor;
         end
         default: w_resWrite = 1'b0;
      endcase
   end

   // Operand latches and architectural HI/LO. HI/LO change only at an
   // mthi/mtlo accept or at the RUN->COMMIT edge (or the early-exit accept).
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_op <= 4'd0;
         r_rs <= 32'd0;
         r_rt <= 32'd0;
         r_hi <= 32'd0;
         r_lo <= 32'd0;
      end else begin
         if (w_latchOps) begin
            r_op <= i_op;
            r_rs <= i_rs;
            r_rt <= i_rt;
         end
         if (w_commit) begin
            if (w_resWrite) begin
               r_hi <= w_resHi;
               r_lo <= w_resLo;
            end
`ifdef MDU_SCHED_EARLY_EXIT_EN
         end else if (w_latchOps && w_shortcut && w_isMul) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
`endif
         end else if (w_accept && (i_op == 4'd5)) begin
            r_hi <= i_rs;
         end else if (w_accept && (i_op == 4'd6)) begin
            r_lo <= i_rs;
         end
      end
   end

   assign o_busy  = (r_state == RUN);
   assign o_done  = (r_state == COMMIT);
   assign o_hi    = r_hi;
   assign o_lo    = r_lo;
   assign o_rdata = (i_op == 4'd7) ? r_hi : (i_op == 4'd8) ? r_lo : 32'd0;

endmodule

// File: tb/tb_mdu_sched.sv
// tb_mdu_sched
// Directed bench for mdu_sched: a table of long operations with
// hand-computed HI/LO and busy lengths, plus hand-written sequences for
// mthi/mtlo/mfhi/mflo, req cancellation, req and stray start during RUN,
// and reset asserted mid-operation.

module tb_mdu_sched;

   logic        clock;
   logic        reset;
   logic        req;
   logic        start;
   logic [3:0]  op;
   logic [31:0] rs;
   logic [31:0] rt;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] rdata;

   int errors = 0;
   int checks = 0;

`ifdef MDU_SCHED_EARLY_EXIT_EN
   localparam int ZERO_MUL_CYC = 0;
   localparam int ZERO_DIV_CYC = 0;
`else
   localparam int ZERO_MUL_CYC = 5;
   localparam int ZERO_DIV_CYC = 10;
`endif

   typedef struct {
      logic [3:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      int          cycles;
      logic [31:0] hi;
      logic [31:0] lo;
      string       name;
   } vec_t;

   vec_t vecs[9];

   mdu_sched #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
      .i_clk   (clock),
      .i_reset (reset),
      .i_req   (req),
      .i_start (start),
      .i_op    (op),
      .i_rs    (rs),
      .i_rt    (rt),
      .o_busy  (busy),
      .o_done  (done),
      .o_hi    (hi),
      .o_lo    (lo),
      .o_rdata (rdata)
   );

   // Free-running clock, 10 time units per period
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one clock and settle just after the edge
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Launch one long op, count busy cycles, then check the COMMIT cycle.
   // With disturb set, req pulses and a stray mthi is presented during RUN.
   task automatic applyStimulus(input logic [3:0] vOp, input logic [31:0] vRs,
                                input logic [31:0] vRt, input int expCycles,
                                input logic [31:0] expHi, input logic [31:0] expLo,
                                input bit disturb, input string name);
      int busyCount;
      start = 1'b1;
      op    = vOp;
      rs    = vRs;
      rt    = vRt;
      step();
      start = 1'b0;
      op    = 4'd0;
      rs    = 32'd0;
      rt    = 32'd0;
      busyCount = 0;
      while (busy && busyCount < 64) begin
         busyCount++;
         if (disturb) begin
            if (busyCount == 2) req = 1'b1;
            if (busyCount == 3) req = 1'b0;
            if (busyCount == 4) begin
               start = 1'b1;
               op    = 4'd5;
               rs    = 32'hDEAD_BEEF;
            end
            if (busyCount == 5) begin
               start = 1'b0;
               op    = 4'd0;
               rs    = 32'd0;
            end
         end
         step();
      end
      checkOutput({name, " busy cycles"}, 32'(busyCount), 32'(expCycles));
      checkOutput({name, " done"}, {31'd0, done}, 32'd1);
      checkOutput({name, " hi"}, hi, expHi);
      checkOutput({name, " lo"}, lo, expLo);
   endtask

   initial begin
      vecs[0] = '{4'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult -2*3"};
      vecs[1] = '{4'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE, "multu ffffffff*2"};
      vecs[2] = '{4'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14, "divu 100/7"};
      vecs[3] = '{4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div -7/2"};
      vecs[4] = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, "div min/-1"};
      vecs[5] = '{4'd1, 32'h0001_0000, 32'h0001_0000, 5, 32'd1, 32'd0, "mult 2^16*2^16"};
      vecs[6] = '{4'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD, "div 7/-2"};
      vecs[7] = '{4'd3, 32'd55, 32'd0, ZERO_DIV_CYC, 32'd1, 32'hFFFF_FFFD, "div by zero"};
      vecs[8] = '{4'd2, 32'h1234_5678, 32'd0, ZERO_MUL_CYC, 32'd0, 32'd0, "multu by zero"};

      reset = 1'b0;
      req   = 1'b0;
      start = 1'b0;
      op    = 4'd0;
      rs    = 32'd0;
      rt    = 32'd0;
      step();
      step();
      checkOutput("reset busy", {31'd0, busy}, 32'd0);
      checkOutput("reset done", {31'd0, done}, 32'd0);
      checkOutput("reset hi", hi, 32'd0);
      checkOutput("reset lo", lo, 32'd0);
      reset = 1'b1;
      step();

      // mthi then mflo/mfhi reads
      start = 1'b1;
      op    = 4'd5;
      rs    = 32'h0000_1234;
      step();
      checkOutput("mthi hi", hi, 32'h0000_1234);
      checkOutput("mthi busy", {31'd0, busy}, 32'd0);
      op = 4'd8;
      #1;
      checkOutput("mflo rdata", rdata, 32'd0);
      op = 4'd7;
      #1;
      checkOutput("mfhi rdata", rdata, 32'h0000_1234);
      step();
      op = 4'd6;
      rs = 32'h0000_ABCD;
      step();
      checkOutput("mtlo lo", lo, 32'h0000_ABCD);
      checkOutput("mtlo hi kept", hi, 32'h0000_1234);
      op = 4'd8;
      #1;
      checkOutput("mflo rdata after mtlo", rdata, 32'h0000_ABCD);
      start = 1'b0;
      op    = 4'd0;
      #1;
      checkOutput("rdata none", rdata, 32'd0);

      // start cancelled by req in the same cycle
      req   = 1'b1;
      start = 1'b1;
      op    = 4'd1;
      rs    = 32'd5;
      rt    = 32'd7;
      step();
      checkOutput("req cancel busy", {31'd0, busy}, 32'd0);
      checkOutput("req cancel done", {31'd0, done}, 32'd0);
      op = 4'd5;
      rs = 32'h0000_9999;
      step();
      checkOutput("req cancel mthi hi", hi, 32'h0000_1234);
      checkOutput("req cancel lo", lo, 32'h0000_ABCD);
      checkOutput("req cancel busy later", {31'd0, busy}, 32'd0);
      req   = 1'b0;
      start = 1'b0;
      op    = 4'd0;
      rs    = 32'd0;
      rt    = 32'd0;

      // Table of long ops, issued back to back (each new start lands in COMMIT)
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].cycles,
                       vecs[i].hi, vecs[i].lo, 1'b0, vecs[i].name);
      end
      step();
      checkOutput("idle after table done", {31'd0, done}, 32'd0);
      checkOutput("idle after table busy", {31'd0, busy}, 32'd0);

      // req and a stray mthi during RUN must not disturb the running divide
      applyStimulus(4'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14, 1'b1, "divu with req in RUN");
      step();
      checkOutput("done one pulse", {31'd0, done}, 32'd0);

      // Reset asserted on the third busy cycle
      start = 1'b1;
      op    = 4'd1;
      rs    = 32'd3;
      rt    = 32'd4;
      step();
      start = 1'b0;
      op    = 4'd0;
      step();
      step();
      checkOutput("mid-run busy before reset", {31'd0, busy}, 32'd1);
      reset = 1'b0;
      #1;
      checkOutput("async reset busy", {31'd0, busy}, 32'd0);
      checkOutput("async reset done", {31'd0, done}, 32'd0);
      checkOutput("async reset hi", hi, 32'd0);
      checkOutput("async reset lo", lo, 32'd0);
      step();
      reset = 1'b1;
      step();
      checkOutput("post reset idle busy", {31'd0, busy}, 32'd0);
      applyStimulus(4'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'd1, 32'hFFFF_FFFE, 1'b0, "multu after reset");
      step();
      checkOutput("final done low", {31'd0, done}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
